tri_l15_responder: RTL and testbench
====================================

Name: tri_l15_responder

Overview:
- Responder end of the TRI request/response interface: plays the L1.5 role toward a TRI initiator (e.g. an accelerator tile wrapper).
- Backed by a local 128-bit-line scratchpad.
- Accepts one request at a time and executes load, store and atomic (swap/add).
- Returns a typed response and holds it until the initiator acknowledges; used as an on-tile scratchpad and as a bench stand-in for the L1.5.

Parameters:
- LINES, 64, number of 16-byte scratchpad lines (power of 2, >=2)
- IDX_W, $clog2(LINES), line index width, derived

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tri_req_val  in  1  request valid
- tri_req_rqtype  in  5  request type
- tri_req_amo_op  in  4  atomic op (valid when rqtype is AMO)
- tri_req_size  in  3  log2(bytes); 0..3 = 1..8 B, 4 = 16 B
- tri_req_address  in  40  physical byte address
- tri_req_data  in  64  data word 0
- tri_req_data_next_entry  in  64  data word 1 (16 B stores)
- tri_req_ack  out  1  one-cycle pulse, request accepted
- tri_resp_val  out  1  response valid
- tri_resp_returntype  out  4  response type
- tri_resp_atomic  out  1  response belongs to an atomic
- tri_resp_data_0  out  64  line bytes 0-7
- tri_resp_data_1  out  64  line bytes 8-15
- tri_resp_inval_address_15_4  out  12  tied 0
- tri_resp_inval_val  out  1  tied 0
- tri_resp_req_ack  in  1  initiator consumed response
- One clock (clk); reset is synchronous and active-high (rst).

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE. Scratchpad contents are not reset.
- Line index = address[4 +: IDX_W]. Higher address bits are ignored, so addresses wrap modulo LINES*16. Word select = address[3].
- FSM states: IDLE, RD, WR, RESP (LAT inserted under feature).
- IDLE: when tri_req_val=1, latch all request fields, pulse tri_req_ack for that cycle, go to RD. tri_req_ack is never asserted outside IDLE. Requests arriving in other states wait.
- RD: issue a synchronous line read; data is available the next cycle.
- Load: go directly to RESP. Response data is the full line as read, regardless of size.
- Store, size 0..3: byte-mask write into the selected word. Mask = (2^size) bytes at offset address[2:0]. Offset is forced to size alignment by clearing the low address bits.
- Store, size 4: write both words (data to bytes 0-7, next_entry to bytes 8-15); address[3] is ignored.
- AMO, size 2 or 3 only:
  - op 1 = swap: new = req_data.
  - op 2 = add: new = old + req_data, modulo the operand width. Size 2 adds only the 32-bit lane selected by address[2] and wraps at 32 bits.
  - Other ops, or AMO of another size: no write; still respond.
- WR: perform the write computed from the read data, then go to RESP.
- Response data for store is all zeros. Response data for AMO is the pre-modification line.
- RESP: drive tri_resp_val=1 with returntype LOAD_RET(0), ST_ACK(4) or ATOMIC_RET(3). tri_resp_atomic=1 only for AMO. Outputs are held stable until a cycle with tri_resp_req_ack=1. That cycle ends the response; next cycle is IDLE with tri_resp_val=0.
- tri_resp_req_ack outside RESP is ignored.
- Unknown rqtype: no memory access; respond ST_ACK with zero data.
- Latency, default build: load 3 cycles from ack cycle to tri_resp_val; store/AMO 4 cycles.
- Minimum turnaround: next request is acknowledged 1 cycle after the response handshake.
- rst mid-operation: the in-flight request is dropped with no response. A write is committed only if WR was reached before the rst cycle.

Optional Feature:
- Macro TRI_L15_RESPONDER_LATENCY_EN.
- When defined: adds input lat_cfg [7:0] and state LAT between RD/WR and RESP. LAT loads an 8-bit down-counter with lat_cfg and waits until it reaches 0, adding lat_cfg cycles. lat_cfg=0 gives the default latency. lat_cfg is sampled on entry to LAT.
- When undefined: no port, no counter, latency as above.

Decomposition:
- Package tri_l15_pkg holds:
  - rqtype enum: RQ_LOAD=0, RQ_STORE=1, RQ_AMO=6
  - returntype enum: LOAD_RET=0, ATOMIC_RET=3, ST_ACK=4
  - amo_op enum: AMO_SWAP=1, AMO_ADD=2
  - FSM state typedef
  - latched-request struct
- Sub-module tri_l15_sram: 1R1W synchronous line array with 16-bit byte-enable.

Test Plan:
- Store size 3, addr 0x40, data 0x1122334455667788; then load addr 0x40 -> LOAD_RET, data_0=0x1122334455667788, ack-to-val 3 cycles.
- Store size 0, addr 0x43, data 0xAB over a zeroed line -> load returns only byte 3 = 0xAB, all other bytes 0.
- Store size 4 at 0x50 (0x01..., 0x02...); AMO add size 2 at 0x54, data 0xFFFFFFFF, over lane 0x00000001 -> ATOMIC_RET, resp_atomic=1, old line returned; reload shows lane 0x00000000 and neighbouring lane unchanged.
- Hold tri_resp_req_ack=0 for 10 cycles with tri_req_val held high -> response fields stable, no second tri_req_ack until 1 cycle after the handshake.
- Address 0x40 and 0x40+LINES*16 alias -> store to the second, load from the first returns the stored data; unknown rqtype 5'd20 -> ST_ACK with zero data.
- Assert rst in RD during a store -> all outputs 0 next cycle, no response, line unchanged. With the feature, lat_cfg=5 -> load latency 8 cycles.

Source files
------------

// File: rtl/tri_l15_pkg.sv
// Shared types for the TRI L1.5 responder: request/response encodings,
// FSM states and the latched request bundle.
package tri_l15_pkg;

   typedef enum logic [4:0] {
      RQ_LOAD  = 5'd0,
      RQ_STORE = 5'd1,
      RQ_AMO   = 5'd6
   } rqtype_e;

   typedef enum logic [3:0] {
      LOAD_RET   = 4'd0,
      ATOMIC_RET = 4'd3,
      ST_ACK     = 4'd4
   } rettype_e;

   typedef enum logic [3:0] {
      AMO_SWAP = 4'd1,
      AMO_ADD  = 4'd2
   } amo_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
`ifdef TRI_L15_RESPONDER_LATENCY_EN
      ST_LAT,
`endif
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [4:0]  rqtype;
      logic [3:0]  amo_op;
      logic [2:0]  size;
      logic [3:0]  off;
      logic [63:0] data0;
      logic [63:0] data1;
   } req_t;

   function automatic logic [7:0] size_mask(input logic [2:0] size);
      unique case (size)
         3'd0:    size_mask = 8'h01;
         3'd1:    size_mask = 8'h03;
         3'd2:    size_mask = 8'h0F;
         3'd3:    size_mask = 8'hFF;
         default: size_mask = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/tri_l15_sram.sv
// 1R1W synchronous scratchpad line array, 16-byte lines, byte-enabled writes.
module tri_l15_sram #(
   parameter int LINES = 64,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic               clk,
   input  logic               rd_en,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [127:0]       rd_data,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [15:0]        wr_be,
   input  logic [127:0]       wr_data
);

   logic [127:0] mem [LINES];

   always_ff @(posedge clk) begin
      if (rd_en)
         rd_data <= mem[rd_idx];
      if (wr_en) begin
         for (int i = 0; i < 16; i++)
            if (wr_be[i])
               mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
   end

endmodule

// File: rtl/tri_l15_responder.sv
// TRI responder acting as L1.5 over a local scratchpad (load/store/AMO).
// Optional TRI_L15_RESPONDER_LATENCY_EN adds lat_cfg and a LAT wait state.
module tri_l15_responder
   import tri_l15_pkg::*;
#(
   parameter int LINES = 64,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic         clk,
   input  logic         rst,
`ifdef TRI_L15_RESPONDER_LATENCY_EN
   input  logic [7:0]   lat_cfg,
`endif
   input  logic         tri_req_val,
   input  logic [4:0]   tri_req_rqtype,
   input  logic [3:0]   tri_req_amo_op,
   input  logic [2:0]   tri_req_size,
   input  logic [39:0]  tri_req_address,
   input  logic [63:0]  tri_req_data,
   input  logic [63:0]  tri_req_data_next_entry,
   output logic         tri_req_ack,
   output logic         tri_resp_val,
   output logic [3:0]   tri_resp_returntype,
   output logic         tri_resp_atomic,
   output logic [63:0]  tri_resp_data_0,
   output logic [63:0]  tri_resp_data_1,
   output logic [11:0]  tri_resp_inval_address_15_4,
   output logic         tri_resp_inval_val,
   input  logic         tri_resp_req_ack
);

   state_e           state_q, state_d, after_op;
   req_t             req_q;
   logic [IDX_W-1:0] idx_q;
   logic             rd_ph_q;
   logic [127:0]     rdata, line_q, rdat_q;
   logic [3:0]       rt_q;
   logic             atom_q;
   logic             ack_c, rd_en, done, we;
   logic             is_load, is_store, is_amo, amo_ok, swap;
   logic [15:0]      be;
   logic [127:0]     wdata;
   logic [7:0]       bm8;
   logic [2:0]       off;
   logic [63:0]      old64, new64;
   logic [31:0]      old32, new32;
   logic             unused_addr;

   assign unused_addr = ^tri_req_address[39:4+IDX_W];

   assign is_load  = req_q.rqtype == RQ_LOAD;
   assign is_store = req_q.rqtype == RQ_STORE;
   assign is_amo   = req_q.rqtype == RQ_AMO;
   assign swap     = req_q.amo_op == AMO_SWAP;
   assign amo_ok   = is_amo
                   && (req_q.size == 3'd2 || req_q.size == 3'd3)
                   && (swap || req_q.amo_op == AMO_ADD);

   always_comb begin
      bm8   = '0;
      off   = '0;
      new64 = '0;
      new32 = '0;
      old64 = req_q.off[3] ? line_q[127:64] : line_q[63:0];
      old32 = req_q.off[2] ? old64[63:32] : old64[31:0];
      if (is_store) begin
         off   = req_q.off[2:0] & (~(3'b111 >> (2'd3 - req_q.size[1:0])));
         bm8   = size_mask(req_q.size) << off;
         new64 = req_q.data0 << {off, 3'b000};
      end else if (amo_ok && req_q.size == 3'd3) begin
         bm8   = 8'hFF;
         new64 = swap ? req_q.data0 : old64 + req_q.data0;
      end else if (amo_ok) begin
         bm8   = req_q.off[2] ? 8'hF0 : 8'h0F;
         new32 = swap ? req_q.data0[31:0] : old32 + req_q.data0[31:0];
         new64 = {new32, new32};
      end
      be    = req_q.off[3] ? {bm8, 8'h00} : {8'h00, bm8};
      wdata = {new64, new64};
      if (is_store && req_q.size == 3'd4) begin
         be    = '1;
         wdata = {req_q.data1, req_q.data0};
      end
   end

   assign we = state_q == ST_WR && !rst && |be;

`ifdef TRI_L15_RESPONDER_LATENCY_EN
   logic [7:0] cnt_q;
   assign after_op = (lat_cfg != 8'd0) ? ST_LAT : ST_RESP;
`else
   assign after_op = ST_RESP;
`endif

   always_comb begin
      state_d = state_q;
      ack_c   = 1'b0;
      rd_en   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tri_req_val) begin
               ack_c   = 1'b1;
               state_d = ST_RD;
            end
         end
         // first RD cycle issues the read, second sees its data
         ST_RD: begin
            if (!rd_ph_q) begin
               rd_en = is_load | is_amo;
            end else if (is_load) begin
               done    = 1'b1;
               state_d = after_op;
            end else begin
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            done    = 1'b1;
            state_d = after_op;
         end
`ifdef TRI_L15_RESPONDER_LATENCY_EN
         ST_LAT: begin
            if (cnt_q == 8'd1)
               state_d = ST_RESP;
         end
`endif
         ST_RESP: begin
            if (tri_resp_req_ack)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rd_ph_q <= 1'b0;
         req_q   <= '0;
         idx_q   <= '0;
         rt_q    <= '0;
         atom_q  <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         rd_ph_q <= state_q == ST_RD && !rd_ph_q;
         if (ack_c) begin
            req_q <= '{rqtype: tri_req_rqtype,
                       amo_op: tri_req_amo_op,
                       size:   tri_req_size,
                       off:    tri_req_address[3:0],
                       data0:  tri_req_data,
                       data1:  tri_req_data_next_entry};
            idx_q <= tri_req_address[4 +: IDX_W];
         end
         if (done) begin
            rt_q   <= is_load ? LOAD_RET : is_amo ? ATOMIC_RET : ST_ACK;
            atom_q <= is_amo;
            rdat_q <= is_load ? rdata : is_amo ? line_q : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_RD && rd_ph_q)
         line_q <= rdata;
   end

`ifdef TRI_L15_RESPONDER_LATENCY_EN
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (state_d == ST_LAT && state_q != ST_LAT)
         cnt_q <= lat_cfg;
      else if (state_q == ST_LAT)
         cnt_q <= cnt_q - 8'd1;
   end
`endif

   tri_l15_sram #(
      .LINES (LINES),
      .IDX_W (IDX_W)
   ) u_sram (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_idx  (idx_q),
      .rd_data (rdata),
      .wr_en   (we),
      .wr_idx  (idx_q),
      .wr_be   (be),
      .wr_data (wdata)
   );

   assign tri_req_ack                 = ack_c & ~rst;
   assign tri_resp_val                = state_q == ST_RESP;
   assign tri_resp_returntype         = tri_resp_val ? rt_q : 4'd0;
   assign tri_resp_atomic             = tri_resp_val & atom_q;
   assign tri_resp_data_0             = tri_resp_val ? rdat_q[63:0] : 64'd0;
   assign tri_resp_data_1             = tri_resp_val ? rdat_q[127:64] : 64'd0;
   assign tri_resp_inval_address_15_4 = '0;
   assign tri_resp_inval_val          = 1'b0;

endmodule

// File: tb/tb_tri_l15_responder.sv
// Directed self-checking bench for tri_l15_responder.
// Hand-computed expectations for load/store/AMO, hold, alias, reset.
module tb_tri_l15_responder;

   logic         clk = 1'b0;
   logic         rst;
   logic         tri_req_val;
   logic [4:0]   tri_req_rqtype;
   logic [3:0]   tri_req_amo_op;
   logic [2:0]   tri_req_size;
   logic [39:0]  tri_req_address;
   logic [63:0]  tri_req_data;
   logic [63:0]  tri_req_data_next_entry;
   logic         tri_req_ack;
   logic         tri_resp_val;
   logic [3:0]   tri_resp_returntype;
   logic         tri_resp_atomic;
   logic [63:0]  tri_resp_data_0;
   logic [63:0]  tri_resp_data_1;
   logic [11:0]  tri_resp_inval_address_15_4;
   logic         tri_resp_inval_val;
   logic         tri_resp_req_ack;
`ifdef TRI_L15_RESPONDER_LATENCY_EN
   logic [7:0]   lat_cfg = 8'd0;
`endif

   always #5 clk = ~clk;

   tri_l15_responder #(.LINES(64)) dut (
      .clk                         (clk),
      .rst                         (rst),
`ifdef TRI_L15_RESPONDER_LATENCY_EN
      .lat_cfg                     (lat_cfg),
`endif
      .tri_req_val                 (tri_req_val),
      .tri_req_rqtype              (tri_req_rqtype),
      .tri_req_amo_op              (tri_req_amo_op),
      .tri_req_size                (tri_req_size),
      .tri_req_address             (tri_req_address),
      .tri_req_data                (tri_req_data),
      .tri_req_data_next_entry     (tri_req_data_next_entry),
      .tri_req_ack                 (tri_req_ack),
      .tri_resp_val                (tri_resp_val),
      .tri_resp_returntype         (tri_resp_returntype),
      .tri_resp_atomic             (tri_resp_atomic),
      .tri_resp_data_0             (tri_resp_data_0),
      .tri_resp_data_1             (tri_resp_data_1),
      .tri_resp_inval_address_15_4 (tri_resp_inval_address_15_4),
      .tri_resp_inval_val          (tri_resp_inval_val),
      .tri_resp_req_ack            (tri_resp_req_ack)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic req_send(input logic [4:0] rq, input logic [3:0] op,
                           input logic [2:0] sz, input logic [39:0] a,
                           input logic [63:0] d0, input logic [63:0] d1);
      int n;
      @(negedge clk);
      tri_req_val             = 1'b1;
      tri_req_rqtype          = rq;
      tri_req_amo_op          = op;
      tri_req_size            = sz;
      tri_req_address         = a;
      tri_req_data            = d0;
      tri_req_data_next_entry = d1;
      #1;
      n = 0;
      while (!tri_req_ack && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_ack", 128'(tri_req_ack), 128'(1));
   endtask

   task automatic resp_wait(output int lat);
      #1;
      lat = 1;
      while (!tri_resp_val && lat < 60) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk("resp_val", 128'(tri_resp_val), 128'(1));
   endtask

   task automatic resp_ack();
      tri_resp_req_ack = 1'b1;
      @(negedge clk);
      tri_resp_req_ack = 1'b0;
   endtask

   task automatic xact(input logic [4:0] rq, input logic [3:0] op,
                       input logic [2:0] sz, input logic [39:0] a,
                       input logic [63:0] d0, input logic [63:0] d1,
                       output logic [3:0] rt, output logic at,
                       output logic [127:0] dat, output int lat);
      req_send(rq, op, sz, a, d0, d1);
      @(negedge clk);
      tri_req_val = 1'b0;
      resp_wait(lat);
      rt  = tri_resp_returntype;
      at  = tri_resp_atomic;
      dat = {tri_resp_data_1, tri_resp_data_0};
      resp_ack();
   endtask

   logic [3:0]   rt;
   logic         at;
   logic [127:0] dat;
   logic [133:0] snap;
   int           lat;
   int           bad;
   int           acks;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                     = 1'b1;
      tri_req_val             = 1'b0;
      tri_req_rqtype          = '0;
      tri_req_amo_op          = '0;
      tri_req_size            = '0;
      tri_req_address         = '0;
      tri_req_data            = '0;
      tri_req_data_next_entry = '0;
      tri_resp_req_ack        = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ack", 128'(tri_req_ack), 128'(0));
      chk("rst_val", 128'(tri_resp_val), 128'(0));
      chk("rst_data", {tri_resp_data_1, tri_resp_data_0}, 128'(0));
      chk("rst_rt", 128'({tri_resp_returntype, tri_resp_atomic}), 128'(0));

      xact(5'd1, 4'd0, 3'd3, 40'h40, 64'h1122334455667788, 64'h0,
           rt, at, dat, lat);
      chk("st8_rt", 128'(rt), 128'(4));
      chk("st8_data", dat, 128'(0));
      chk("st8_lat", 128'(lat), 128'(4));
      xact(5'd0, 4'd0, 3'd0, 40'h40, 64'h0, 64'h0, rt, at, dat, lat);
      chk("ld_rt", 128'(rt), 128'(0));
      chk("ld_atomic", 128'(at), 128'(0));
      chk("ld_data0", 128'(dat[63:0]), 128'(64'h1122334455667788));
      chk("ld_lat", 128'(lat), 128'(3));

      xact(5'd1, 4'd0, 3'd4, 40'h40, 64'h0, 64'h0, rt, at, dat, lat);
      xact(5'd1, 4'd0, 3'd0, 40'h43, 64'hFFFFFFFFFFFFFFAB, 64'h0,
           rt, at, dat, lat);
      xact(5'd0, 4'd0, 3'd0, 40'h40, 64'h0, 64'h0, rt, at, dat, lat);
      chk("st1_byte3", dat, 128'h00000000AB000000);

      xact(5'd1, 4'd0, 3'd4, 40'h50, 64'h00000001CAFEF00D,
           64'h0202020202020202, rt, at, dat, lat);
      xact(5'd6, 4'd2, 3'd2, 40'h54, 64'hFFFFFFFFFFFFFFFF, 64'h0,
           rt, at, dat, lat);
      chk("amo_rt", 128'(rt), 128'(3));
      chk("amo_atomic", 128'(at), 128'(1));
      chk("amo_old", dat, {64'h0202020202020202, 64'h00000001CAFEF00D});
      chk("amo_lat", 128'(lat), 128'(4));
      xact(5'd0, 4'd0, 3'd0, 40'h50, 64'h0, 64'h0, rt, at, dat, lat);
      chk("amo_add_wrap", dat,
          {64'h0202020202020202, 64'h00000000CAFEF00D});
      xact(5'd6, 4'd1, 3'd3, 40'h58, 64'h1234, 64'h0, rt, at, dat, lat);
      chk("swap_old", dat, {64'h0202020202020202, 64'h00000000CAFEF00D});
      xact(5'd0, 4'd0, 3'd0, 40'h50, 64'h0, 64'h0, rt, at, dat, lat);
      chk("swap_new", dat, {64'h0000000000001234, 64'h00000000CAFEF00D});

      // response hold with a second request pending
      req_send(5'd0, 4'd0, 3'd0, 40'h50, 64'h0, 64'h0);
      @(negedge clk);
      tri_req_address = 40'h40;
      resp_wait(lat);
      snap = {tri_resp_returntype, tri_resp_atomic, tri_resp_val,
              tri_resp_data_1, tri_resp_data_0};
      chk("hold_data", snap[127:0],
          {64'h0000000000001234, 64'h00000000CAFEF00D});
      bad  = 0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (snap != {tri_resp_returntype, tri_resp_atomic, tri_resp_val,
                      tri_resp_data_1, tri_resp_data_0})
            bad++;
         if (tri_req_ack)
            acks++;
      end
      chk("hold_stable", 128'(bad), 128'(0));
      chk("hold_no_ack", 128'(acks), 128'(0));
      resp_ack();
      #1;
      chk("turnaround_ack", 128'(tri_req_ack), 128'(1));
      chk("post_hs_val", 128'(tri_resp_val), 128'(0));
      @(negedge clk);
      tri_req_val = 1'b0;
      resp_wait(lat);
      chk("second_ld", {tri_resp_data_1, tri_resp_data_0},
          128'h00000000AB000000);
      resp_ack();

      xact(5'd1, 4'd0, 3'd3, 40'h440, 64'hDEADBEEF0BADF00D, 64'h0,
           rt, at, dat, lat);
      xact(5'd0, 4'd0, 3'd0, 40'h40, 64'h0, 64'h0, rt, at, dat, lat);
      chk("alias", 128'(dat[63:0]), 128'(64'hDEADBEEF0BADF00D));
      xact(5'd20, 4'd0, 3'd3, 40'h40, 64'h5555, 64'h0, rt, at, dat, lat);
      chk("unk_rt", 128'(rt), 128'(4));
      chk("unk_data", dat, 128'(0));
      chk("unk_atomic", 128'(at), 128'(0));

      xact(5'd1, 4'd0, 3'd4, 40'h60, 64'hA0A0A0A0A0A0A0A0,
           64'hA1A1A1A1A1A1A1A1, rt, at, dat, lat);
      req_send(5'd1, 4'd0, 3'd4, 40'h60, 64'hB0B0B0B0B0B0B0B0,
               64'hB1B1B1B1B1B1B1B1);
      @(negedge clk);
      tri_req_val = 1'b0;
      rst         = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_out", 128'({tri_req_ack, tri_resp_val, tri_resp_atomic,
                               tri_resp_returntype}), 128'(0));
      chk("mid_rst_data", {tri_resp_data_1, tri_resp_data_0}, 128'(0));
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (tri_resp_val)
            bad++;
      end
      chk("mid_rst_noresp", 128'(bad), 128'(0));
      xact(5'd0, 4'd0, 3'd0, 40'h60, 64'h0, 64'h0, rt, at, dat, lat);
      chk("mid_rst_line", dat,
          {64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0});

`ifdef TRI_L15_RESPONDER_LATENCY_EN
      lat_cfg = 8'd5;
      xact(5'd0, 4'd0, 3'd0, 40'h60, 64'h0, 64'h0, rt, at, dat, lat);
      chk("lat5_ld", 128'(lat), 128'(8));
      lat_cfg = 8'd0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
